// File: rtl/lane_serializer.sv
// Frame-to-lane serializer: captures a MSG_SIZE-bit frame and emits it LANES bits per beat.
// Define SERIALIZER_PARITY_EN to append an even-parity beat after the last data beat.
module lane_serializer #(
   parameter int MSG_SIZE = 64,
   parameter int LANES    = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic [MSG_SIZE-1:0] iData_in,
   input  logic                iValid,
   input  logic                iLsbFirst,
   output logic                oReady,
   output logic [LANES-1:0]    oData_out,
   output logic                oData_flag,
   output logic                oDone
);

   localparam int BEATS = MSG_SIZE / LANES;
   localparam int CNT_W = $clog2(BEATS + 1);

   generate
      if ((MSG_SIZE < 2) || (LANES < 1) || ((MSG_SIZE % LANES) != 0)) begin : g_bad_cfg
         $error("lane_serializer: MSG_SIZE must be >= 2 and a multiple of LANES");
      end
   endgenerate

`ifdef SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
   logic par_q;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [MSG_SIZE-1:0] shreg;
   logic                lsb_q;

   // The beat leaving the frame is always at the end the order points to.
   function automatic logic [LANES-1:0] head_beat(input logic [MSG_SIZE-1:0] d,
                                                  input logic lsb);
      return lsb ? d[LANES-1:0] : d[MSG_SIZE-1 -: LANES];
   endfunction

   function automatic logic [MSG_SIZE-1:0] drop_beat(input logic [MSG_SIZE-1:0] d,
                                                     input logic lsb);
      return lsb ? (d >> LANES) : (d << LANES);
   endfunction

   assign oReady = (state == IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         lsb_q      <= 1'b0;
         oData_out  <= '0;
         oData_flag <= 1'b0;
         oDone      <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         oDone <= 1'b0;
         if (ena) begin
            case (state)
               IDLE: begin
                  if (iValid) begin
                     // Beat 0 goes out on the capture edge; the register keeps the rest.
                     oData_out  <= head_beat(iData_in, iLsbFirst);
                     oData_flag <= 1'b1;
                     shreg      <= drop_beat(iData_in, iLsbFirst);
                     lsb_q      <= iLsbFirst;
                     cnt        <= CNT_W'(BEATS - 1);
                     state      <= SHIFT;
`ifdef SERIALIZER_PARITY_EN
                     par_q      <= ^iData_in;
`endif
                  end
               end
               SHIFT: begin
                  if (cnt != '0) begin
                     oData_out <= head_beat(shreg, lsb_q);
                     shreg     <= drop_beat(shreg, lsb_q);
                     cnt       <= cnt - CNT_W'(1);
                  end else begin
`ifdef SERIALIZER_PARITY_EN
                     oData_out <= {LANES{par_q}};
                     state     <= PARITY;
`else
                     oData_out  <= '0;
                     oData_flag <= 1'b0;
                     oDone      <= 1'b1;
                     state      <= IDLE;
`endif
                  end
               end
`ifdef SERIALIZER_PARITY_EN
               PARITY: begin
                  oData_out  <= '0;
                  oData_flag <= 1'b0;
                  oDone      <= 1'b1;
                  state      <= IDLE;
               end
`endif
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lane_serializer.sv
// Directed bench for lane_serializer: 8x1 and 16x4 instances on a shared clock.
// Parity-beat checks are enabled when SERIALIZER_PARITY_EN is defined.
module tb_lane_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance a: MSG_SIZE=8, LANES=1
   logic       a_rst_n, a_ena, a_valid, a_lsb;
   logic [7:0] a_din;
   logic       a_ready, a_dout, a_flag, a_done;

   // Instance b: MSG_SIZE=16, LANES=4
   logic        b_rst_n, b_ena, b_valid, b_lsb;
   logic [15:0] b_din;
   logic        b_ready, b_flag, b_done;
   logic [3:0]  b_dout;

   int n_tests = 0;
   int n_fail  = 0;
   int fl_cnt;

   lane_serializer #(.MSG_SIZE(8), .LANES(1)) u_a (
      .clk(clk), .rst_n(a_rst_n), .ena(a_ena), .iData_in(a_din), .iValid(a_valid),
      .iLsbFirst(a_lsb), .oReady(a_ready), .oData_out(a_dout), .oData_flag(a_flag),
      .oDone(a_done)
   );

   lane_serializer #(.MSG_SIZE(16), .LANES(4)) u_b (
      .clk(clk), .rst_n(b_rst_n), .ena(b_ena), .iData_in(b_din), .iValid(b_valid),
      .iLsbFirst(b_lsb), .oReady(b_ready), .oData_out(b_dout), .oData_flag(b_flag),
      .oDone(b_done)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts enabled edges that leave oData_flag high on instance b.
   task automatic step_cnt();
      logic en_at_edge;
      en_at_edge = b_ena;
      @(posedge clk);
      #1;
      if (en_at_edge && b_flag) fl_cnt++;
   endtask

   task automatic b_beat(input string tag, input logic [3:0] exp_b);
      check_val({tag, "_data"}, {28'd0, b_dout}, {28'd0, exp_b});
      check_val({tag, "_flag"}, {31'd0, b_flag}, 32'd1);
      check_val({tag, "_rdy"},  {31'd0, b_ready}, 32'd0);
   endtask

   task automatic b_end(input string tag);
      check_val({tag, "_done"},   {31'd0, b_done}, 32'd1);
      check_val({tag, "_eflag"},  {31'd0, b_flag}, 32'd0);
      check_val({tag, "_edata"},  {28'd0, b_dout}, 32'd0);
      check_val({tag, "_erdy"},   {31'd0, b_ready}, 32'd1);
      step();
      check_val({tag, "_doneclr"}, {31'd0, b_done}, 32'd0);
   endtask

   task automatic frame_b(input string tag, input logic [15:0] d, input logic lsb,
                          input logic [3:0] e0, input logic [3:0] e1,
                          input logic [3:0] e2, input logic [3:0] e3, input logic par);
      b_din = d; b_lsb = lsb; b_valid = 1'b1;
      step(); b_beat({tag, "_b0"}, e0);
      b_valid = 1'b0;
      step(); b_beat({tag, "_b1"}, e1);
      step(); b_beat({tag, "_b2"}, e2);
      step(); b_beat({tag, "_b3"}, e3);
`ifdef SERIALIZER_PARITY_EN
      step(); b_beat({tag, "_par"}, {4{par}});
`else
      if (par === 1'bx) $display("note: parity argument unused");
`endif
      step(); b_end(tag);
   endtask

   // exp_bits holds the hand-written MSB-first bit stream of the frame.
   task automatic frame_a(input string tag, input logic [7:0] d, input logic [7:0] exp_bits,
                          input logic par);
      a_din = d; a_lsb = 1'b0; a_valid = 1'b1;
      step();
      a_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check_val($sformatf("%s_bit%0d", tag, k), {31'd0, a_dout}, {31'd0, exp_bits[7-k]});
         check_val($sformatf("%s_flag%0d", tag, k), {31'd0, a_flag}, 32'd1);
         step();
      end
`ifdef SERIALIZER_PARITY_EN
      check_val({tag, "_par"}, {31'd0, a_dout}, {31'd0, par});
      check_val({tag, "_parflag"}, {31'd0, a_flag}, 32'd1);
      step();
`else
      if (par === 1'bx) $display("note: parity argument unused");
`endif
      check_val({tag, "_done"}, {31'd0, a_done}, 32'd1);
      check_val({tag, "_eflag"}, {31'd0, a_flag}, 32'd0);
      check_val({tag, "_rdy"}, {31'd0, a_ready}, 32'd1);
      step();
      check_val({tag, "_doneclr"}, {31'd0, a_done}, 32'd0);
   endtask

   initial begin
      a_rst_n = 1'b0; a_ena = 1'b1; a_valid = 1'b0; a_lsb = 1'b0; a_din = 8'h00;
      b_rst_n = 1'b0; b_ena = 1'b1; b_valid = 1'b0; b_lsb = 1'b0; b_din = 16'h0000;
      step(); step();
      check_val("rst_a_data", {31'd0, a_dout}, 32'd0);
      check_val("rst_a_flag", {31'd0, a_flag}, 32'd0);
      check_val("rst_a_done", {31'd0, a_done}, 32'd0);
      check_val("rst_a_rdy",  {31'd0, a_ready}, 32'd1);
      check_val("rst_b_data", {28'd0, b_dout}, 32'd0);
      check_val("rst_b_rdy",  {31'd0, b_ready}, 32'd1);
      a_rst_n = 1'b1; b_rst_n = 1'b1;

      // ena low in IDLE blocks capture
      b_ena = 1'b0; b_valid = 1'b1; b_din = 16'h1234;
      step();
      check_val("idle_stall_rdy",  {31'd0, b_ready}, 32'd1);
      check_val("idle_stall_flag", {31'd0, b_flag}, 32'd0);
      b_valid = 1'b0; b_ena = 1'b1;

      frame_a("a5", 8'hA5, 8'b1010_0101, 1'b0);
      frame_a("a4", 8'hA4, 8'b1010_0100, 1'b1);

      frame_b("msb", 16'h1234, 1'b0, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
      frame_b("lsb", 16'h1234, 1'b1, 4'h4, 4'h3, 4'h2, 4'h1, 1'b1);

      // Stall for three cycles after beat 1
      fl_cnt = 0;
      b_din = 16'h1234; b_lsb = 1'b0; b_valid = 1'b1;
      step_cnt(); b_beat("st_b0", 4'h1);
      b_valid = 1'b0;
      step_cnt(); b_beat("st_b1", 4'h2);
      b_ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step_cnt();
         b_beat($sformatf("st_hold%0d", i), 4'h2);
         check_val($sformatf("st_hold_done%0d", i), {31'd0, b_done}, 32'd0);
      end
      b_ena = 1'b1;
      step_cnt(); b_beat("st_b2", 4'h3);
      step_cnt(); b_beat("st_b3", 4'h4);
`ifdef SERIALIZER_PARITY_EN
      step_cnt(); b_beat("st_par", 4'hF);
      check_val("st_flagcnt", fl_cnt, 32'd5);
`else
      check_val("st_flagcnt", fl_cnt, 32'd4);
`endif
      step_cnt(); b_end("st");

      // Reset at beat 2, then capture immediately after
      b_din = 16'h1234; b_lsb = 1'b0; b_valid = 1'b1;
      step(); b_beat("rs_b0", 4'h1);
      b_valid = 1'b0;
      step(); b_beat("rs_b1", 4'h2);
      step(); b_beat("rs_b2", 4'h3);
      b_rst_n = 1'b0;
      step();
      check_val("rs_data", {28'd0, b_dout}, 32'd0);
      check_val("rs_flag", {31'd0, b_flag}, 32'd0);
      check_val("rs_done", {31'd0, b_done}, 32'd0);
      check_val("rs_rdy",  {31'd0, b_ready}, 32'd1);
      b_rst_n = 1'b1;
      frame_b("beef", 16'hBEEF, 1'b0, 4'hB, 4'hE, 4'hE, 4'hF, 1'b1);

      // iValid and new data during an active frame are ignored
      b_din = 16'h1234; b_lsb = 1'b0; b_valid = 1'b1;
      step(); b_beat("iv_b0", 4'h1);
      b_din = 16'hFFFF; b_lsb = 1'b1;
      step(); b_beat("iv_b1", 4'h2);
      step(); b_beat("iv_b2", 4'h3);
      b_valid = 1'b0;
      step(); b_beat("iv_b3", 4'h4);
`ifdef SERIALIZER_PARITY_EN
      step(); b_beat("iv_par", 4'hF);
`endif
      step(); b_end("iv");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
